uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 91 +++++++++
 tb/tb_uart_tx_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, frame-locked scheduler feeding one UART byte transmitter
module uart_tx_sched #(
  parameter int N             = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_int,
  input  logic                 bps_start,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  input  logic                 err_clr
);
  localparam int IW   = $clog2(N);
  localparam int MAXC = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr_ptr, sel, idx;
  logic [CW-1:0] cnt, cnt_inc;
  logic lock, found, accept, timeout, to_done, gap_done;
  int j;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
    return (v == IW'(N - 1)) ? '0 : v + 1'b1;
  endfunction
  always_comb begin
    j = 0;
    idx = '0;
    sel = grant_id;
    found = 1'b0;
    if (lock) found = req_valid[grant_id];
    else
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        idx = IW'((j >= N) ? j - N : j);
        if (req_valid[idx]) begin
          found = 1'b1;
          sel = idx;
        end
      end
    accept = state == IDLE && found;
    req_ready = '0;
    req_ready[sel] = accept;
    to_done = int'(cnt) + 1 >= START_TIMEOUT;
    gap_done = int'(cnt) + 1 >= GAP_CYCLES;
    timeout = state == START && !bps_start && to_done;
    cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    tx_int = state != START;
    busy = state != IDLE;
    state_d = state;
    case (state)
      IDLE:      state_d = found ? START : IDLE;
      START:     state_d = bps_start ? WAIT_DONE : (to_done ? GAP : START);
      WAIT_DONE: state_d = bps_start ? WAIT_DONE : ((GAP_CYCLES == 0) ? IDLE : GAP);
      GAP:       state_d = gap_done ? IDLE : GAP;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      lock <= 1'b0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (state_d != state) ? '0 : cnt_inc;
      if (accept) begin
        tx_data <= req_data[8*sel +: 8];
        grant_id <= sel;
        lock <= !req_last[sel];
        if (req_last[sel]) rr_ptr <= inc(sel);
      end
      if (timeout) begin
        lock <= 1'b0;
        rr_ptr <= inc(grant_id);
      end
      err_timeout <= timeout | (err_timeout & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench with a frame-level arbitration model and a transmitter model
module tb_uart_tx_sched;
  localparam int N = 4, GAP = 16, TO = 64, BIT = 4, FRAME = 10 * BIT;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_int, bps_start = 0, busy, err_timeout, err_clr = 0;
  logic [1:0] grant_id;
  logic [1:0] g_valid = '0, g_last = '0, g_ready;
  logic [15:0] g_data = '0;
  logic [7:0] g_txd;
  logic g_txi, g_bps = 0, g_busy, g_err;
  logic [0:0] g_gid;
  uart_tx_sched #(.N(N), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_int(tx_int), .bps_start(bps_start),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr));
  uart_tx_sched #(.N(2), .GAP_CYCLES(0), .START_TIMEOUT(TO)) u_g0 (
    .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(g_data), .req_last(g_last),
    .req_ready(g_ready), .tx_data(g_txd), .tx_int(g_txi), .bps_start(g_bps),
    .grant_id(g_gid), .busy(g_busy), .err_timeout(g_err), .err_clr(1'b0));
  typedef struct {int id; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  logic [7:0] line_q[$];
  logic [8:0] pq[N][$];
  int mp = 0, vec = 0, errs = 0;
  logic tx_en = 1, chk_gap = 1;
  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  // Whole frames are granted in round-robin order starting at the pointer.
  task automatic model();
    logic [8:0] mq[N][$];
    logic [8:0] b;
    int o;
    for (int k = 0; k < N; k++) mq[k] = pq[k];
    forever begin
      o = -1;
      for (int k = 0; k < N; k++) if (o < 0 && mq[(mp + k) % N].size() != 0) o = (mp + k) % N;
      if (o < 0) break;
      do begin
        b = mq[o].pop_front();
        exp_q.push_back('{o, b[7:0]});
        line_q.push_back(b[7:0]);
      end while (!b[8]);
      mp = (o + 1) % N;
    end
  endtask
  function automatic bit pending();
    for (int k = 0; k < N; k++) if (pq[k].size() != 0) return 1;
    return 0;
  endfunction
  task automatic wait_done(input string nm);
    int n = 0;
    while (n < 3000 && (exp_q.size() != 0 || line_q.size() != 0 || busy || pending())) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, int'(n < 3000), 1);
  endtask
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        req_valid[i] = pq[i].size() != 0;
        req_last[i] = req_valid[i] && pq[i][0][8];
        req_data[8*i +: 8] = req_valid[i] ? pq[i][0][7:0] : 8'h00;
      end
    end
  end
  initial begin
    exp_t e, pe;
    bit pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("tx_data", tx_data, pe.d);
        chk("grant_id", grant_id, pe.id);
        pend = 0;
      end
      if (req_ready != 0 && !rst) begin
        if (exp_q.size() == 0) chk("spurious_ready", req_ready, 0);
        else begin
          e = exp_q.pop_front();
          chk("req_ready", req_ready, 1 << e.id);
          pe = e;
          pend = 1;
        end
      end
    end
  end
  initial begin
    bit d1 = 1, started = 0, gapping = 0;
    int dly = 0, fcnt = 0, lowcnt = 0, gcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bps_start = 1;
          fcnt = FRAME;
          if (line_q.size() == 0) chk("line_unexpected", line_q.size(), 1);
          else chk("line_byte", tx_data, line_q.pop_front());
        end
      end else if (bps_start) begin
        fcnt--;
        if (fcnt == 0) begin
          bps_start = 0;
          gapping = chk_gap;
          gcnt = 0;
        end
      end
      if (gapping) begin
        if (busy && gcnt < 200) gcnt++;
        else begin
          chk("gap_len", gcnt, GAP + 1);
          gapping = 0;
        end
      end
      if (d1 && !tx_int && tx_en) begin
        dly = 2;
        lowcnt = 0;
        started = 1;
      end
      if (!d1 && tx_int && started) begin
        chk("tx_int_low", lowcnt, 3);
        started = 0;
      end
      if (!tx_int) lowcnt++;
      d1 = tx_int;
    end
  end
  initial begin
    bit d1 = 1;
    int dly = 0, fc = 0;
    forever begin
      @(posedge clk); #1;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          g_bps = 1;
          fc = FRAME;
        end
      end else if (g_bps) begin
        fc--;
        if (fc == 0) g_bps = 0;
      end
      if (d1 && !g_txi) dly = 2;
      d1 = g_txi;
    end
  end
  initial begin
    int n, m, tot, nf, len, r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_int", tx_int, 1);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst = 0;
    pq[0].push_back({1'b1, 8'hA0});
    pq[0].push_back({1'b1, 8'hA4});
    pq[1].push_back({1'b1, 8'hA1});
    pq[2].push_back({1'b1, 8'hA2});
    pq[3].push_back({1'b1, 8'hA3});
    model();
    wait_done("rr_round");
    pq[0].push_back({1'b1, 8'h55});
    model();
    wait_done("single_byte");
    pq[2].push_back({1'b0, 8'h11});
    pq[2].push_back({1'b1, 8'h22});
    pq[0].push_back({1'b1, 8'h33});
    pq[3].push_back({1'b1, 8'h44});
    model();
    wait_done("lock_round");
    tx_en = 0;
    pq[1].push_back({1'b0, 8'h7E});
    exp_q.push_back('{1, 8'h7E});
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
    chk("to_accept", req_ready[1], 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!err_timeout && n < 200);
    chk("timeout_cycles", n, TO + 1);
    chk("timeout_busy", busy, 1);
    m = 0;
    while (busy && m < 100) begin @(posedge clk); #1; m++; end
    chk("timeout_gap", m, GAP);
    chk("err_sticky", err_timeout, 1);
    mp = 2;
    tx_en = 1;
    pq[0].push_back({1'b1, 8'h33});
    pq[1].push_back({1'b1, 8'h44});
    model();
    wait_done("after_timeout");
    chk("err_held", err_timeout, 1);
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("err_cleared", err_timeout, 0);
    chk_gap = 0;
    pq[3].push_back({1'b0, 8'h5A});
    exp_q.push_back('{3, 8'h5A});
    line_q.push_back(8'h5A);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bps_start && n < 50);
    chk("bps_seen", bps_start, 1);
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mr_tx_int", tx_int, 1);
    chk("mr_busy", busy, 0);
    chk("mr_tx_data", tx_data, 0);
    chk("mr_grant_id", grant_id, 0);
    chk("mr_req_ready", req_ready, 0);
    chk("mr_err", err_timeout, 0);
    mp = 0;
    n = 0;
    while (bps_start && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk_gap = 1;
    pq[0].push_back({1'b1, 8'h66});
    pq[3].push_back({1'b1, 8'h77});
    model();
    wait_done("post_reset");
    for (r = 0; r < 8; r++) begin
      tot = 0;
      for (int i = 0; i < N; i++) begin
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            pq[i].push_back({b == len - 1, 8'($urandom)});
            tot++;
          end
        end
      end
      if (tot == 0) pq[$urandom_range(0, N - 1)].push_back({1'b1, 8'($urandom)});
      model();
      wait_done("rand_round");
    end
    g_valid = 2'b01;
    g_data[7:0] = 8'h61;
    g_last = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (!g_ready[0] && n < 20);
    chk("g0_first_ready", g_ready, 1);
    @(posedge clk); #1;
    g_data[7:0] = 8'h62;
    @(negedge clk);
    chk("g0_tx_data", g_txd, 8'h61);
    n = 0;
    while (!g_bps && n < 20) begin @(negedge clk); n++; end
    chk("g0_ready_busy", g_ready, 0);
    n = 0;
    while (g_bps && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!g_ready[0] && n < 10) begin @(negedge clk); n++; end
    chk("g0_back_to_back", n, 1);
    @(posedge clk); #1;
    g_valid = '0;
    @(negedge clk);
    chk("g0_tx_data2", g_txd, 8'h62);
    chk("g0_gid", g_gid, 0);
    n = 0;
    while ((g_busy || g_bps) && n < 200) begin @(negedge clk); n++; end
    chk("g0_idle", g_busy, 0);
    chk("g0_err", g_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
